// File: rtl/dsp_bram_pkg.sv
// Shared definitions for the equalizer debug capture path: controller state encoding and
// address-width derivation.
package dsp_bram_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPre   = 3'd1,
    StPost  = 3'd2,
    StFull  = 3'd3,
    StPrime = 3'd4,
    StRead  = 3'd5
  } cap_state_e;

  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/bram_rd_stream.sv
// Readout side of the capture controller: read pointer/count, RAM port-B address advance and
// last-word marking. The parent FSM sequences PRIME/READ and tells this block when to load.
module bram_rd_stream
  import dsp_bram_pkg::*;
#(
  parameter int unsigned DEPTH  = 32768,
  parameter int unsigned ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_ptr,
  input  logic              reading,
  input  logic              rd_ready,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              last_fire
);
  localparam int unsigned CntW = ADDR_W + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DEPTH - 1);

  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   rd_cnt_q, rd_cnt_d;
  logic              fire;

  assign rd_valid  = reading;
  assign rd_last   = reading && (rd_cnt_q == LastCnt);
  assign fire      = reading && rd_ready;
  assign last_fire = fire && rd_last;

  // Presenting the next address in the accepting cycle keeps the one-cycle RAM latency hidden.
  always_comb begin
    ram_addr_b = fire ? rd_ptr_q + 1'b1 : rd_ptr_q;
    rd_ptr_d   = load ? load_ptr : ram_addr_b;
    rd_cnt_d   = rd_cnt_q;
    if (load) begin
      rd_cnt_d = '0;
    end else if (fire) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

endmodule

// File: rtl/bram_capture_ctrl.sv
// Capture/readout controller: circular pre-trigger capture into a dual-port RAM through port A,
// then chronological readout of the whole buffer through port B over valid/ready.
module bram_capture_ctrl
  import dsp_bram_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32768,
  parameter int unsigned PRE_TRIG = 8192,
  localparam int unsigned ADDR_W  = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              abort,
  input  logic              din_valid,
  input  logic [WIDTH-1:0]  din,
  input  logic              trigger,
  input  logic              read_start,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [WIDTH-1:0]  ram_din,
  output logic [ADDR_W-1:0] ram_addr_b,
  input  logic [WIDTH-1:0]  ram_dout_b,
  output logic              rd_valid,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_last,
  input  logic              rd_ready,
  output logic              busy,
  output logic              done
);
  localparam int unsigned CntW = ADDR_W + 1;
  localparam logic [CntW-1:0] PreTrig = CntW'(PRE_TRIG);
  localparam logic [CntW-1:0] PostLen = CntW'(DEPTH - PRE_TRIG);

  cap_state_e        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   pre_cnt_q, pre_cnt_d;
  logic [CntW-1:0]   post_cnt_q, post_cnt_d;
  logic              done_q, done_d;
  logic              load_rd;
  logic              last_fire;

  assign ram_we     = din_valid && (state_q == StPre || state_q == StPost) && !abort;
  assign ram_addr_a = wr_ptr_q;
  assign ram_din    = din;
  assign rd_data    = ram_dout_b;
  assign busy       = (state_q != StIdle);
  assign done       = done_q;
  assign done_d     = last_fire && !abort;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    pre_cnt_d  = pre_cnt_q;
    post_cnt_d = post_cnt_q;
    load_rd    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arm) begin
          state_d   = StPre;
          wr_ptr_d  = '0;
          pre_cnt_d = '0;
        end
      end
      StPre: begin
        if (din_valid) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (pre_cnt_q != PreTrig) pre_cnt_d = pre_cnt_q + 1'b1;
          // The qualifying trigger sample is itself the first post-trigger sample.
          if (trigger && pre_cnt_q == PreTrig) begin
            post_cnt_d = CntW'(1);
            if (PostLen == CntW'(1)) begin
              state_d = StFull;
              load_rd = 1'b1;
            end else begin
              state_d = StPost;
            end
          end
        end
      end
      StPost: begin
        if (din_valid) begin
          wr_ptr_d   = wr_ptr_q + 1'b1;
          post_cnt_d = post_cnt_q + 1'b1;
          if (post_cnt_d == PostLen) begin
            state_d = StFull;
            load_rd = 1'b1;
          end
        end
      end
      StFull: begin
        if (read_start) state_d = StPrime;
      end
      StPrime: state_d = StRead;
      StRead: begin
        if (last_fire) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (abort) begin
      state_d = StIdle;
      load_rd = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      pre_cnt_q  <= '0;
      post_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      pre_cnt_q  <= pre_cnt_d;
      post_cnt_q <= post_cnt_d;
      done_q     <= done_d;
    end
  end

  // The oldest retained sample sits at the final write pointer.
  bram_rd_stream #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_rd_stream (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load_rd),
    .load_ptr   (wr_ptr_d),
    .reading    (state_q == StRead),
    .rd_ready   (rd_ready),
    .ram_addr_b (ram_addr_b),
    .rd_valid   (rd_valid),
    .rd_last    (rd_last),
    .last_fire  (last_fire)
  );

endmodule

// File: tb/tb_bram_capture_ctrl.sv
// Bench for bram_capture_ctrl with a behavioural dual-port RAM and a readout scoreboard.
module tb_bram_capture_ctrl;
  localparam int unsigned WIDTH    = 32;
  localparam int unsigned DEPTH    = 16;
  localparam int unsigned PRE_TRIG = 4;
  localparam int unsigned AW       = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             arm = 1'b0, abort = 1'b0, din_valid = 1'b0, trigger = 1'b0;
  logic             read_start = 1'b0, rd_ready = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             ram_we, rd_valid, rd_last, busy, done;
  logic [AW-1:0]    ram_addr_a, ram_addr_b;
  logic [WIDTH-1:0] ram_din, rd_data;
  logic [WIDTH-1:0] ram_dout_b = '0;
  logic [WIDTH-1:0] mem [DEPTH];

  int n_checks = 0;
  int n_errors = 0;
  int hist[$];
  int exp_q[$];
  int we_err, addr_err;

  typedef struct {
    int trig_k;
    int early_k;
    int gap;
    bit bp;
    int exp_first;
    int exp_last;
  } vec_t;
  vec_t vecs[4];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr_a] <= ram_din;
    ram_dout_b <= mem[ram_addr_b];
  end

  bram_capture_ctrl #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .PRE_TRIG (PRE_TRIG)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arm        (arm),
    .abort      (abort),
    .din_valid  (din_valid),
    .din        (din),
    .trigger    (trigger),
    .read_start (read_start),
    .ram_we     (ram_we),
    .ram_addr_a (ram_addr_a),
    .ram_din    (ram_din),
    .ram_addr_b (ram_addr_b),
    .ram_dout_b (ram_dout_b),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_last    (rd_last),
    .rd_ready   (rd_ready),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_arm();
    hist.delete();
    we_err   = 0;
    addr_err = 0;
    @(negedge clk);
    arm = 1'b1; din_valid = 1'b0; trigger = 1'b0;
    @(posedge clk);
    #1 arm = 1'b0;
  endtask

  task automatic send(input int k, input bit trig);
    @(negedge clk);
    din_valid = 1'b1; din = WIDTH'(100 + k); trigger = trig;
    #1;
    if (ram_we !== 1'b1) we_err++;
    if (ram_addr_a !== AW'(k % DEPTH) || ram_din !== din) addr_err++;
    hist.push_back(100 + k);
  endtask

  // Trigger held high while invalid: it must only be sampled with din_valid.
  task automatic idle_cyc();
    @(negedge clk);
    din_valid = 1'b0; din = 32'hDEAD_BEEF; trigger = 1'b1;
    #1;
    if (ram_we !== 1'b0) we_err++;
  endtask

  task automatic capture(input int trig_k, input int early_k, input int gap);
    do_arm();
    for (int k = 0; k <= trig_k + int'(DEPTH - PRE_TRIG) - 1; k++) begin
      for (int g = 1; g < gap; g++) idle_cyc();
      send(k, (k == trig_k) || (k == early_k));
    end
    @(negedge clk);
    din_valid = 1'b1; din = 32'd999; trigger = 1'b0;
    #1;
    check("we_in_full", ram_we, 0);
    check("busy_full", busy, 1);
    check("we_gating", we_err, 0);
    check("wr_addr_data", addr_err, 0);
    din_valid = 1'b0;
    exp_q.delete();
    for (int i = hist.size() - int'(DEPTH); i < hist.size(); i++) exp_q.push_back(hist[i]);
  endtask

  task automatic readout(input bit bp, output int first, output int last);
    int got, cyc, stall_err, e;
    bit stalled;
    logic [WIDTH-1:0] held;
    got = 0; cyc = 0; stall_err = 0; stalled = 1'b0; held = '0;
    first = -1; last = -1;
    @(negedge clk);
    read_start = 1'b1; rd_ready = 1'b0;
    @(negedge clk);
    read_start = 1'b0;
    #1;
    check("prime_no_valid", rd_valid, 0);
    while (got < int'(DEPTH) && cyc < 400) begin
      @(negedge clk);
      rd_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      cyc++;
      if (stalled && (rd_valid !== 1'b1 || rd_data !== held)) stall_err++;
      stalled = 1'b0;
      if (rd_valid === 1'b1 && rd_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        check("rd_data", rd_data, e);
        check("rd_last", rd_last, exp_q.size() == 0);
        if (got == 0) first = int'(rd_data);
        last = int'(rd_data);
        got++;
      end else if (rd_valid === 1'b1) begin
        stalled = 1'b1;
        held    = rd_data;
      end
    end
    check("rd_count", got, DEPTH);
    if (!bp) check("rd_cycles", cyc, DEPTH);
    check("stall_hold", stall_err, 0);
    @(negedge clk);
    rd_ready = 1'b0;
    #1;
    check("done_pulse", done, 1);
    check("idle_valid", rd_valid, 0);
    check("idle_busy", busy, 0);
    @(negedge clk);
    #1;
    check("done_once", done, 0);
  endtask

  initial begin
    int first, last;
    vecs[0] = '{trig_k: 9, early_k: -1, gap: 1, bp: 1'b0, exp_first: 105, exp_last: 120};
    vecs[1] = '{trig_k: 9, early_k: 2,  gap: 1, bp: 1'b0, exp_first: 105, exp_last: 120};
    vecs[2] = '{trig_k: 9, early_k: -1, gap: 1, bp: 1'b1, exp_first: 105, exp_last: 120};
    vecs[3] = '{trig_k: 9, early_k: -1, gap: 3, bp: 1'b0, exp_first: 105, exp_last: 120};

    #1;
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_addr_b", ram_addr_b, 0);
    check("rst_we", ram_we, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk); read_start = 1'b1;
    @(negedge clk); read_start = 1'b0;
    #1 check("read_start_in_idle", busy, 0);
    @(negedge clk); arm = 1'b1; abort = 1'b1;
    @(negedge clk); arm = 1'b0; abort = 1'b0;
    #1 check("abort_beats_arm", busy, 0);

    for (int v = 0; v < 4; v++) begin
      capture(vecs[v].trig_k, vecs[v].early_k, vecs[v].gap);
      readout(vecs[v].bp, first, last);
      check($sformatf("vec%0d_first", v), first, vecs[v].exp_first);
      check($sformatf("vec%0d_last", v), last, vecs[v].exp_last);
    end

    // Abort in POST on the sample k=12, then a clean re-capture.
    do_arm();
    for (int k = 0; k < 12; k++) send(k, k == 9);
    @(negedge clk);
    din_valid = 1'b1; din = 32'd112; abort = 1'b1;
    #1;
    check("abort_we", ram_we, 0);
    @(negedge clk);
    abort = 1'b0; din_valid = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_no_done", done, 0);
    @(negedge clk);
    #1 check("abort_no_done_late", done, 0);
    capture(9, -1, 1);
    readout(1'b0, first, last);
    check("rearm_first", first, 105);
    check("rearm_last", last, 120);

    // Asynchronous reset between clock edges in the middle of readout.
    capture(9, -1, 1);
    @(negedge clk); read_start = 1'b1; rd_ready = 1'b1;
    @(negedge clk); read_start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rd_valid", rd_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_addr_b", ram_addr_b, 0);
    rd_ready = 1'b0;
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_idle", busy, 0);
    check("post_rst_done", done, 0);
    @(negedge clk); arm = 1'b1;
    @(negedge clk); arm = 1'b0;
    #1 check("post_rst_arm", busy, 1);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
